bfly_sdf_ctrl: RTL and testbench
================================

Name: bfly_sdf_ctrl

Overview:
Single-path delay-feedback (SDF) stage controller that sits on the other side of the bfly datapath interface. It produces the din1/din2 vector pairs and bfly_en for the butterfly. It stores the butterfly's difference outputs and merges sums and stored differences into one in-order stage output stream. It handles 16-lane parallel I/Q vectors, one vector per clock.

Parameters:
- WIDTH, 9: input sample width (SIG+INT+FLT, signed).
- LANES, 16: parallel lanes per vector.
- DEPTH, 512: butterfly span in vectors. One frame = 2*DEPTH vectors. The default matches the bfly twiddle sweep.
- AW, $clog2(DEPTH): buffer pointer width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  controller can accept input
- in_i/in_q  in  WIDTH x LANES  signed input vector
- bfly_en  out  1  butterfly phase active; goes to bfly
- din1_i/din1_q  out  WIDTH x LANES  current input (second-half sample)
- din2_i/din2_q  out  WIDTH x LANES  delayed buffer head (first-half sample)
- sum_i/sum_q  in  WIDTH+1 x LANES  bfly dout1 return
- dif_i/dif_q  in  WIDTH+1 x LANES  bfly dout2 return
- out_valid  out  1  output vector valid
- out_i/out_q  out  WIDTH+1 x LANES  stage output
- err  out  1  one-cycle pulse on mid-frame valid gap

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, ptr=0, bfly_en=0, out_valid=0, out_i/q=0, err=0, in_ready=0. Buffer contents are don't-care.
- Buffer: DEPTH x LANES x WIDTH+1 register array, circular, single pointer ptr. Combinational read at ptr; write at ptr on the clock edge (read-before-write). ptr wraps DEPTH-1 -> 0.
- Input stored in the buffer is sign-extended to WIDTH+1. din2 takes the low WIDTH bits of the buffer head. This is lossless because FILL data fits WIDTH.
- The bfly return path is combinational. sum/dif are sampled in the same cycle bfly_en is high.
- Outputs are registered with 1-cycle latency.
- IDLE:
  - in_ready=1.
  - On in_valid: write input at ptr=0, go to FILL with ptr=1. out_valid stays 0 because there is no pending difference.
- FILL (DEPTH vectors):
  - in_ready=1.
  - Each cycle: write input to buffer[ptr]. If a pending difference block exists, the buffer head (old difference) goes to out next cycle with out_valid=1.
  - After the DEPTH-th vector, go to BFLY with ptr=0.
- BFLY (DEPTH vectors):
  - in_ready=1. bfly_en = in_valid.
  - din1 = input, din2 = buffer head.
  - sum goes to out next cycle with out_valid=1. dif is written to buffer[ptr].
  - After DEPTH vectors, set pending=1. If in_valid is high on the next cycle, go to FILL; otherwise go to DRAIN.
- DRAIN:
  - in_ready=0; in_valid is ignored.
  - Outputs DEPTH stored differences, one per cycle, with out_valid=1.
  - Then go to IDLE with pending=0.
- FILL entered directly from BFLY:
  - Outputs differences while accepting the new frame, giving gapless back-to-back frames.
- Valid gap (in_valid=0 while in FILL or BFLY, except at a frame boundary):
  - err pulses 1 cycle, go to IDLE, ptr=0, pending=0. Partial data is discarded.
  - bfly_en drops immediately.
- bfly_en is held continuously for exactly DEPTH cycles per frame, so the bfly twiddle counter sweeps correctly.
- Reset mid-frame: immediate return to the reset values above. No output flush.
- Output ordering per frame: DEPTH sums (frame k), then DEPTH differences (frame k). The differences are emitted during frame k+1's FILL or during DRAIN.

Optional Feature:
- Macro BFLY_SDF_ERRCNT_EN.
- Defined: adds output port err_cnt [7:0], a saturating count of err pulses. It clears only on reset and holds at 255.
- Undefined: the port and counter are absent; err pulse behaviour is unchanged.

Decomposition:
- Shared package fft_pkg:
  - state enum sdf_state_t {IDLE, FILL, BFLY, DRAIN}
  - default WIDTH/LANES constants
  - lane vector typedefs (sample_t, sample_ext_t as WIDTH+1)
- One sub-module, sdf_dly_mem: the circular buffer with read-before-write and pointer wrap. Instantiated twice, once for I and once for Q, sharing the pointer.

Test Plan (DEPTH=4, LANES=16, bfly modelled combinationally):
- Reset: hold rstn=0 for 2 cycles with random inputs -> all outputs 0, in_ready=0; in_ready=1 on the cycle after release.
- Single frame: lane0 I inputs 1,2,3,4,5,6,7,8 -> bfly_en high for exactly cycles 5–8 with din2=1..4 and din1=5..8. Out (identity twiddle) = sums 6,8,10,12, then DRAIN differences -4,-4,-4,-4 with in_ready=0. out_valid is high for 8 cycles total.
- Back-to-back frames: two frames sent continuously -> frame-1 differences are interleaved during frame-2 FILL; no out_valid gap; 16 valid outputs.
- Width extremes: input -256 paired with 255 -> sum -1, difference -511; both fit WIDTH+1 with no wrap.
- Valid gap: in_valid drops in BFLY cycle 2 -> err pulse for 1 cycle, state IDLE, bfly_en=0. The next frame processes correctly.
- BFLY_SDF_ERRCNT_EN defined: 300 induced gaps -> err_cnt=255.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage controllers: the SDF state encoding,
// default sample geometry and lane-vector types.
package fft_pkg;

  // Default sample geometry (sign + integer + fraction bits, lanes per vector)
  localparam int SDF_WIDTH = 9;
  localparam int SDF_LANES = 16;
  localparam int SDF_DEPTH = 512;

  // Controller phases within one frame
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2,
    DRAIN = 2'd3
  } sdf_state_t;

  // One lane sample and its one-bit-wider butterfly result
  typedef logic signed [SDF_WIDTH-1:0] sample_t;
  typedef logic signed [SDF_WIDTH:0]   sample_ext_t;

  // Full parallel vectors at the default geometry
  typedef sample_t     [SDF_LANES-1:0] sample_vec_t;
  typedef sample_ext_t [SDF_LANES-1:0] sample_ext_vec_t;

endpackage

// File: rtl/sdf_dly_mem.sv
// Circular delay buffer for one SDF stage component (I or Q).
// The pointer is owned by the caller so that the I and Q copies stay in lock
// step. Reads are combinational at the pointer; a write at the same pointer
// lands on the clock edge, so a cycle sees the old entry (read-before-write).
module sdf_dly_mem #(
  parameter int DEPTH = 512,
  parameter int LANES = 16,
  parameter int DW    = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [AW-1:0]             ptr,
  input  logic [LANES-1:0][DW-1:0]  wdata,
  output logic [LANES-1:0][DW-1:0]  rdata
);

  logic [LANES-1:0][DW-1:0] mem [DEPTH];

  assign rdata = mem[ptr];

  // Store a whole vector at the shared pointer; contents need no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[ptr] <= wdata;
    end
  end

endmodule

// File: rtl/bfly_sdf_ctrl.sv
// Single-path delay-feedback stage controller for the bfly datapath.
// Feeds din1/din2 pairs and bfly_en to the butterfly, parks the butterfly
// differences in a circular buffer and merges sums and differences into one
// in-order output stream (DEPTH sums, then DEPTH differences, per frame).
// DEPTH must be a power of two and at least 2.
// Optional: define BFLY_SDF_ERRCNT_EN to add the saturating err_cnt output.
module bfly_sdf_ctrl
  import fft_pkg::*;
#(
  parameter int WIDTH = SDF_WIDTH,
  parameter int LANES = SDF_LANES,
  parameter int DEPTH = SDF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]  in_i,
  input  logic [LANES-1:0][WIDTH-1:0]  in_q,
  output logic                         bfly_en,
  output logic [LANES-1:0][WIDTH-1:0]  din1_i,
  output logic [LANES-1:0][WIDTH-1:0]  din1_q,
  output logic [LANES-1:0][WIDTH-1:0]  din2_i,
  output logic [LANES-1:0][WIDTH-1:0]  din2_q,
  input  logic [LANES-1:0][WIDTH:0]    sum_i,
  input  logic [LANES-1:0][WIDTH:0]    sum_q,
  input  logic [LANES-1:0][WIDTH:0]    dif_i,
  input  logic [LANES-1:0][WIDTH:0]    dif_q,
  output logic                         out_valid,
  output logic [LANES-1:0][WIDTH:0]    out_i,
  output logic [LANES-1:0][WIDTH:0]    out_q,
  output logic                         err
`ifdef BFLY_SDF_ERRCNT_EN
  ,
  output logic [7:0]                   err_cnt
`endif
);

  sdf_state_t state, state_n;

  logic [AW-1:0] ptr, ptr_n, ptr_inc;
  logic          ptr_last;
  logic          pending, pending_n;

  logic wr_en;
  logic wr_dif;
  logic out_head;
  logic out_sum;
  logic err_n;
  logic in_ready_n;
  logic out_valid_n;

  logic [LANES-1:0][WIDTH:0] in_ext_i, in_ext_q;
  logic [LANES-1:0][WIDTH:0] wr_i, wr_q;
  logic [LANES-1:0][WIDTH:0] head_i, head_q;
  logic [LANES-1:0][WIDTH:0] out_i_n, out_q_n;

  // Pointer advance with wrap at the end of the buffer
  assign ptr_last = (ptr == AW'(DEPTH - 1));
  assign ptr_inc  = ptr_last ? '0 : ptr + AW'(1);

  // The current input is always the second-half sample of the pair
  assign din1_i = in_i;
  assign din1_q = in_q;

  // Widen inputs for storage and narrow the buffer head for the butterfly
  always_comb begin
    in_ext_i = '0;
    in_ext_q = '0;
    din2_i   = '0;
    din2_q   = '0;
    for (int l = 0; l < LANES; l++) begin
      in_ext_i[l] = {in_i[l][WIDTH-1], in_i[l]};
      in_ext_q[l] = {in_q[l][WIDTH-1], in_q[l]};
      din2_i[l]   = head_i[l][WIDTH-1:0];
      din2_q[l]   = head_q[l][WIDTH-1:0];
    end
  end

  // Phase sequencing: decides buffer writes, output source and error pulses
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    pending_n = pending;
    wr_en     = 1'b0;
    wr_dif    = 1'b0;
    out_head  = 1'b0;
    out_sum   = 1'b0;
    err_n     = 1'b0;
    bfly_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          wr_en   = 1'b1;
          ptr_n   = ptr_inc;
          state_n = FILL;
        end
      end
      FILL: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          out_head = pending;
          ptr_n    = ptr_inc;
          if (ptr_last) begin
            state_n   = BFLY;
            pending_n = 1'b0;
          end
        end else if (pending && (ptr == '0)) begin
          // Frame boundary with no follow-on frame: this cycle is the first drain beat
          out_head = 1'b1;
          ptr_n    = ptr_inc;
          state_n  = DRAIN;
        end else begin
          err_n     = 1'b1;
          state_n   = IDLE;
          ptr_n     = '0;
          pending_n = 1'b0;
        end
      end
      BFLY: begin
        bfly_en = in_valid;
        if (in_valid) begin
          wr_en   = 1'b1;
          wr_dif  = 1'b1;
          out_sum = 1'b1;
          ptr_n   = ptr_inc;
          if (ptr_last) begin
            state_n   = FILL;
            pending_n = 1'b1;
          end
        end else begin
          err_n     = 1'b1;
          state_n   = IDLE;
          ptr_n     = '0;
          pending_n = 1'b0;
        end
      end
      DRAIN: begin
        out_head = 1'b1;
        ptr_n    = ptr_inc;
        if (ptr_last) begin
          state_n   = IDLE;
          pending_n = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        ptr_n     = '0;
        pending_n = 1'b0;
      end
    endcase
  end

  // Buffer write source and next output word
  always_comb begin
    wr_i        = wr_dif ? dif_i : in_ext_i;
    wr_q        = wr_dif ? dif_q : in_ext_q;
    out_valid_n = out_head | out_sum;
    in_ready_n  = (state_n != DRAIN);
    out_i_n     = '0;
    out_q_n     = '0;
    if (out_sum) begin
      out_i_n = sum_i;
      out_q_n = sum_q;
    end else if (out_head) begin
      out_i_n = head_i;
      out_q_n = head_q;
    end
  end

  sdf_dly_mem #(
    .DEPTH (DEPTH),
    .LANES (LANES),
    .DW    (WIDTH + 1),
    .AW    (AW)
  ) u_mem_i (
    .clk   (clk),
    .we    (wr_en),
    .ptr   (ptr),
    .wdata (wr_i),
    .rdata (head_i)
  );

  sdf_dly_mem #(
    .DEPTH (DEPTH),
    .LANES (LANES),
    .DW    (WIDTH + 1),
    .AW    (AW)
  ) u_mem_q (
    .clk   (clk),
    .we    (wr_en),
    .ptr   (ptr),
    .wdata (wr_q),
    .rdata (head_q)
  );

  // State, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      ptr       <= '0;
      pending   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      pending   <= pending_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_i     <= out_i_n;
      out_q     <= out_q_n;
      err       <= err_n;
    end
  end

`ifdef BFLY_SDF_ERRCNT_EN
  // Saturating tally of gap errors, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (err_n && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bfly_sdf_ctrl.sv
// Scoreboard bench for bfly_sdf_ctrl at DEPTH=4 with a combinational
// identity-twiddle butterfly (sum = din2 + din1, dif = din2 - din1).
// Define BFLY_SDF_ERRCNT_EN to also exercise err_cnt saturation.
module tb_bfly_sdf_ctrl;
  import fft_pkg::*;

  localparam int WIDTH = 9;
  localparam int LANES = 16;
  localparam int DEPTH = 4;
  localparam int EW    = WIDTH + 1;
  localparam int CW    = LANES * EW;

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
  typedef logic [LANES-1:0][EW-1:0]    evec_t;
  typedef struct packed {
    evec_t i;
    evec_t q;
  } exp_t;

  logic  clk = 1'b0;
  logic  rstn;
  logic  in_valid;
  logic  in_ready;
  vec_t  in_i, in_q;
  logic  bfly_en;
  vec_t  din1_i, din1_q, din2_i, din2_q;
  evec_t sum_i, sum_q, dif_i, dif_q;
  logic  out_valid;
  evec_t out_i, out_q;
  logic  err;
`ifdef BFLY_SDF_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  int   validCount = 0;
  int   run = 0;
  int   maxRun = 0;
  int   errPulses = 0;
  exp_t expQ[$];
  exp_t monExp;
  int   frameI[2*DEPTH];
  int   frameQ[2*DEPTH];

  bfly_sdf_ctrl #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_i      (in_i),
    .in_q      (in_q),
    .bfly_en   (bfly_en),
    .din1_i    (din1_i),
    .din1_q    (din1_q),
    .din2_i    (din2_i),
    .din2_q    (din2_q),
    .sum_i     (sum_i),
    .sum_q     (sum_q),
    .dif_i     (dif_i),
    .dif_q     (dif_q),
    .out_valid (out_valid),
    .out_i     (out_i),
    .out_q     (out_q),
    .err       (err)
`ifdef BFLY_SDF_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Identity-twiddle butterfly, active only while bfly_en is high
  always_comb begin
    sum_i = '0;
    sum_q = '0;
    dif_i = '0;
    dif_q = '0;
    if (bfly_en) begin
      for (int l = 0; l < LANES; l++) begin
        sum_i[l] = {din2_i[l][WIDTH-1], din2_i[l]} + {din1_i[l][WIDTH-1], din1_i[l]};
        sum_q[l] = {din2_q[l][WIDTH-1], din2_q[l]} + {din1_q[l][WIDTH-1], din1_q[l]};
        dif_i[l] = {din2_i[l][WIDTH-1], din2_i[l]} - {din1_i[l][WIDTH-1], din1_i[l]};
        dif_q[l] = {din2_q[l][WIDTH-1], din2_q[l]} - {din1_q[l][WIDTH-1], din1_q[l]};
      end
    end
  end

  task automatic checkOutput(input string name, input logic [CW-1:0] act,
                             input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Lane l carries v (+l when spread) truncated to the input width
  function automatic vec_t buildVec(input int v, input bit spread);
    vec_t r;
    for (int l = 0; l < LANES; l++) r[l] = WIDTH'(v + (spread ? l : 0));
    return r;
  endfunction

  function automatic evec_t expVec(input int a, input int b, input bit spread,
                                   input bit dif);
    evec_t r;
    int    av, bv;
    for (int l = 0; l < LANES; l++) begin
      av   = a + (spread ? l : 0);
      bv   = b + (spread ? l : 0);
      r[l] = EW'(dif ? (av - bv) : (av + bv));
    end
    return r;
  endfunction

  // Drive one vector and wait to the middle of its cycle
  task automatic applyStimulus(input bit valid, input int vi, input int vq,
                               input bit spread);
    in_valid = valid;
    in_i     = buildVec(vi, spread);
    in_q     = buildVec(vq, spread);
    @(negedge clk);
  endtask

  // Send frameI/frameQ as one full frame and queue its sums then differences
  task automatic sendFrame(input bit spread);
    exp_t e;
    for (int k = 0; k < 2*DEPTH; k++) begin
      applyStimulus(1'b1, frameI[k], frameQ[k], spread);
      checkOutput("in_ready", CW'(in_ready), CW'(1));
      if (k < DEPTH) begin
        checkOutput("bfly_en_fill", CW'(bfly_en), CW'(0));
      end else begin
        checkOutput("bfly_en_bfly", CW'(bfly_en), CW'(1));
        checkOutput("din1_i", CW'(din1_i), CW'(buildVec(frameI[k], spread)));
        checkOutput("din1_q", CW'(din1_q), CW'(buildVec(frameQ[k], spread)));
        checkOutput("din2_i", CW'(din2_i), CW'(buildVec(frameI[k-DEPTH], spread)));
        checkOutput("din2_q", CW'(din2_q), CW'(buildVec(frameQ[k-DEPTH], spread)));
        e.i = expVec(frameI[k-DEPTH], frameI[k], spread, 1'b0);
        e.q = expVec(frameQ[k-DEPTH], frameQ[k], spread, 1'b0);
        expQ.push_back(e);
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < DEPTH; d++) begin
      e.i = expVec(frameI[d], frameI[d+DEPTH], spread, 1'b1);
      e.q = expVec(frameQ[d], frameQ[d+DEPTH], spread, 1'b1);
      expQ.push_back(e);
    end
  endtask

  // Idle the input until the controller is back in IDLE with nothing owed
  task automatic drainWait();
    int n;
    n = 0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    while (!(in_ready && (expQ.size() == 0))) begin
      if (n == 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Monitor: every valid output must match the head of the scoreboard
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (out_valid) begin
        validCount++;
        run++;
        if (run > maxRun) maxRun = run;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out: got %0h, expected no output", out_i);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("out_i", CW'(out_i), CW'(monExp.i));
          checkOutput("out_q", CW'(out_q), CW'(monExp.q));
        end
      end else begin
        run = 0;
      end
      if (err) errPulses++;
    end
  end

  initial begin
    int startCount;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_i     = '0;
    in_q     = '0;

    // Reset held two edges with random inputs
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'($urandom);
      for (int l = 0; l < LANES; l++) begin
        in_i[l] = WIDTH'($urandom);
        in_q[l] = WIDTH'($urandom);
      end
      @(posedge clk); #1;
      if (c == 0) begin
        @(negedge clk);
        checkOutput("rst_out_valid", CW'(out_valid), CW'(0));
        checkOutput("rst_out_i", CW'(out_i), CW'(0));
        checkOutput("rst_out_q", CW'(out_q), CW'(0));
        checkOutput("rst_err", CW'(err), CW'(0));
        checkOutput("rst_in_ready", CW'(in_ready), CW'(0));
        checkOutput("rst_bfly_en", CW'(bfly_en), CW'(0));
      end
    end
    rstn     = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_release", CW'(in_ready), CW'(0));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("in_ready_after", CW'(in_ready), CW'(1));
    @(posedge clk); #1;

    // Single frame followed by a drain
    $display("[TB] single frame");
    frameI = '{1, 2, 3, 4, 5, 6, 7, 8};
    frameQ = '{8, 7, 6, 5, 4, 3, 2, 1};
    startCount = validCount;
    sendFrame(1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("in_ready_drain", CW'(in_ready), CW'(0));
    drainWait();
    checkOutput("single_valid_count", CW'(validCount - startCount), CW'(8));
    checkOutput("single_no_err", CW'(errPulses), CW'(0));

    // Back-to-back frames; the second one carries the width extremes
    $display("[TB] back-to-back frames");
    startCount = validCount;
    maxRun     = 0;
    frameI = '{-100, -50, 0, 50, 100, -20, 30, -70};
    frameQ = '{3, -3, 7, -7, 11, -11, 0, 2};
    sendFrame(1'b1);
    frameI = '{-256, -256, -256, -256, 255, 255, 255, 255};
    frameQ = '{255, 255, 255, 255, -256, -256, -256, -256};
    sendFrame(1'b0);
    drainWait();
    checkOutput("b2b_valid_count", CW'(validCount - startCount), CW'(16));
    checkOutput("b2b_gapless", CW'(maxRun), CW'(16));
    checkOutput("b2b_no_err", CW'(errPulses), CW'(0));

    // Valid gap on the second BFLY cycle
    $display("[TB] valid gap");
    frameI = '{10, 20, 30, 40, 1, 2, 3, 4};
    frameQ = '{-1, -2, -3, -4, 5, 6, 7, 8};
    begin
      exp_t e;
      for (int k = 0; k <= DEPTH; k++) begin
        applyStimulus(1'b1, frameI[k], frameQ[k], 1'b1);
        if (k == DEPTH) begin
          e.i = expVec(frameI[0], frameI[DEPTH], 1'b1, 1'b0);
          e.q = expVec(frameQ[0], frameQ[DEPTH], 1'b1, 1'b0);
          expQ.push_back(e);
        end
        @(posedge clk); #1;
      end
    end
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkOutput("bfly_en_gap", CW'(bfly_en), CW'(0));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("err_pulse", CW'(err), CW'(1));
    checkOutput("state_idle", CW'(dut.state), CW'(IDLE));
    checkOutput("in_ready_gap", CW'(in_ready), CW'(1));
    checkOutput("bfly_en_after", CW'(bfly_en), CW'(0));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("err_one_cycle", CW'(err), CW'(0));
    checkOutput("err_pulses", CW'(errPulses), CW'(1));
`ifdef BFLY_SDF_ERRCNT_EN
    checkOutput("err_cnt_one", CW'(err_cnt), CW'(1));
`endif
    drainWait();
    frameI = '{9, -9, 4, -4, 2, 2, -6, 6};
    frameQ = '{0, 1, 2, 3, 4, 5, 6, 7};
    sendFrame(1'b1);
    drainWait();
    checkOutput("err_pulses_clean", CW'(errPulses), CW'(1));

`ifdef BFLY_SDF_ERRCNT_EN
    // Many induced gaps drive the counter into saturation
    $display("[TB] err_cnt saturation");
    for (int g = 0; g < 300; g++) begin
      applyStimulus(1'b1, 1, 1, 1'b0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 0, 0, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("err_pulses_many", CW'(errPulses), CW'(301));
    checkOutput("err_cnt_sat", CW'(err_cnt), CW'(255));
`endif

    checkOutput("queue_empty", CW'(expQ.size()), CW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
